pipelined_barrelshifter: RTL and testbench
==========================================

// Module: pipelined_barrelshifter
// PURPOSE
//  Pipelined, flow-controlled successor to the combinational barrel shifter.
//  Width is parametrised, and the log2(D_SIZE) mux levels are spread over PIPE_STAGES registered stages.
//  Uses the same op encoding, adds a carry flag (CF), and has a valid/ready handshake on both sides.
//  Sits between the operand-issue stage and the ALU result/flags writeback.
// PARAMETERS
//  D_SIZE       32  data width; power of two, >= 4
//  PIPE_STAGES  2   number of register stages; 1..$clog2(D_SIZE); equals latency in cycles
// PORTS
//  clk_in     input   1                 clock, rising edge
//  rst_in     input   1                 asynchronous, active-high reset
//  valid_in   input   1                 upstream operand valid
//  ready_out  output  1                 block can accept an operand this cycle
//  x_in       input   D_SIZE            operand
//  s_in       input   $clog2(D_SIZE)    shift amount, 0..D_SIZE-1
//  op_in      input   3                 operation select (see BEHAVIOUR)
//  valid_out  output  1                 result valid
//  ready_in   input   1                 downstream accepts result
//  y_out      output  D_SIZE            result
//  zf_out     output  1                 zero flag: y_out == 0
//  vf_out     output  1                 overflow flag (ASL only)
//  cf_out     output  1                 carry: last bit shifted or rotated out
// BEHAVIOUR
//  - Reset (async assert, sync deassert is upstream's job): all stage valids, valid_out, y_out, zf/vf/cf_out = 0.
//  - Op encoding:
//    000 LSR; 001 ASR; 01x ROR; 100 LSL; 101 ASL; 11x ROL.
//  - ASL: y[N-1] = x[N-1] (sign held); y[N-2:0] = (x<<s)[N-2:0].
//    vf = 1 iff s != 0 and any of x[N-2 : N-1-s] differs from x[N-1].
//    vf = 0 for every other op.
//  - ASR fills with x[N-1]. LSR and LSL fill with 0.
//  - CF, when s == 0: cf = 0 for all ops.
//  - CF, when s > 0:
//    LSR/ASR: cf = x[s-1].  LSL/ASL: cf = x[N-s].  ROR: cf = y[N-1].  ROL: cf = y[0].
//  - zf is computed on the final y, so it is 1 for any op producing all-zero, including s == 0 with x == 0.
//  - Pipeline structure:
//    Levels 0..L-1 (L = $clog2(D_SIZE)) are split over the stages, earliest stages taking any remainder.
//    Each stage registers its partial result together with x, s, op and a valid bit.
//    Flags are computed combinationally from the last stage and registered with y.
//  - Handshake:
//    advance = !valid_out || ready_in; ready_out = advance.
//    On advance, every stage shifts forward one, and stage 0 loads the input if valid_in is high, else a bubble.
//    When advance = 0, all stages and outputs hold, regardless of valid_in.
//  - Result timing: an operand accepted in cycle t has valid_out high from t+PIPE_STAGES (no stall).
//  - Output stability: y/flags stay stable while valid_out && !ready_in.
//  - Throughput: 1 op/cycle with ready_in held high. Bubbles are squashed only when they reach the output
//    (no internal compaction). Order is always preserved.
//  - Capacity: PIPE_STAGES operands. With ready_in low, ready_out drops once valid_out is high.
//  - Reset mid-operation: all in-flight operands are discarded and no valid_out appears for them.
//  - s_in and op_in are sampled only on accept; changing them while ready_out = 0 has no effect.
// TESTING (D_SIZE=8, PIPE_STAGES=2)
//  - ASR x=0x96 s=3 -> y=0xF2, cf=1, zf=0, vf=0, valid_out 2 cycles after accept.
//  - ASL x=0x30 s=2 -> y=0x40, vf=1, cf=0.
//    ASL x=0xE0 s=2 -> y=0x80, vf=0.
//  - ROL x=0x81 s=1 -> y=0x03, cf=1.
//    ROR x=0x81 s=1 -> y=0xC0, cf=1.
//    LSR x=0x01 s=1 -> y=0x00, zf=1, cf=1.
//  - Streaming: 16 back-to-back random ops with ready_in=1 -> one result per cycle,
//    matching the reference model, in order.
//  - Backpressure: ready_in=0 while issuing 3 ops -> 2 accepted, then ready_out=0 and y_out held.
//    Release -> results drain in order, third op accepted, none lost or duplicated.
//  - Reset: assert rst_in with 2 ops in flight -> outputs 0 immediately; after release,
//    no stale valid_out and the first new op returns at the correct latency.

Source files
------------

// File: rtl/pipelined_barrelshifter_if.sv
// Operand/result handshake bundle for the pipelined barrel shifter.
// Signal names are from the shifter's side; the slave modport is the shifter.
interface pipelined_barrelshifter_if #(
  parameter int D_SIZE = 32
);
  localparam int SW = $clog2(D_SIZE);

  logic              valid_in;
  logic              ready_out;
  logic [D_SIZE-1:0] x_in;
  logic [SW-1:0]     s_in;
  logic [2:0]        op_in;
  logic              valid_out;
  logic              ready_in;
  logic [D_SIZE-1:0] y_out;
  logic              zf_out;
  logic              vf_out;
  logic              cf_out;

  modport master (
    output valid_in, x_in, s_in, op_in, ready_in,
    input  ready_out, valid_out, y_out,
    input  zf_out, vf_out, cf_out
  );

  modport slave (
    input  valid_in, x_in, s_in, op_in, ready_in,
    output ready_out, valid_out, y_out,
    output zf_out, vf_out, cf_out
  );
endinterface

// File: rtl/pipelined_barrelshifter.sv
// Pipelined barrel shifter: log2(D_SIZE) mux levels spread over
// PIPE_STAGES registers, with ZF/VF/CF flags and valid/ready flow control.
module pipelined_barrelshifter #(
  parameter int D_SIZE      = 32,
  parameter int PIPE_STAGES = 2
) (
  input logic                  clk_in,
  input logic                  rst_in,
  pipelined_barrelshifter_if.slave bus
);
  localparam int N  = D_SIZE;
  localparam int L  = $clog2(N);
  localparam int P  = PIPE_STAGES;
  localparam int SW = L;

  typedef struct packed {
    logic          v;
    logic [N-1:0]  p;
    logic [N-1:0]  x;
    logic [SW-1:0] s;
    logic [2:0]    op;
  } stage_t;

  // First level handled by stage k; earlier stages absorb the remainder.
  function automatic int lo_lvl(input int k);
    int b;
    int r;
    b = L / P;
    r = L % P;
    return k * b + ((k < r) ? k : r);
  endfunction

  function automatic logic [N-1:0] lvl(
    input logic [N-1:0] p,
    input int           a,
    input logic [2:0]   op
  );
    logic [N-1:0] r;
    r = '0;
    unique case (1'b1)
      (op[2] && op[1]):
        r = (p << a) | (p >> (N - a));
      (op[2] && !op[1]):
        r = p << a;
      (!op[2] && op[1]):
        r = (p >> a) | (p << (N - a));
      (!op[2] && !op[1] && op[0]):
        r = $signed(p) >>> a;
      default:
        r = p >> a;
    endcase
    return r;
  endfunction

  logic   adv;
  logic   valid_q;
  stage_t last;

  assign adv           = !valid_q || bus.ready_in;
  assign bus.ready_out = adv;

  for (genvar k = 0; k < P; k++) begin : stg
    localparam int LO = lo_lvl(k);
    localparam int HI = lo_lvl(k + 1);

    stage_t d;
    stage_t c;

    if (k == 0) begin : src
      assign d = '{
        v:  bus.valid_in,
        p:  bus.x_in,
        x:  bus.x_in,
        s:  bus.s_in,
        op: bus.op_in
      };
    end else begin : src
      assign d = stg[k-1].r.q;
    end

    always_comb begin
      logic [SW-1:0] sb;
      c  = d;
      sb = '0;
      for (int j = LO; j < HI; j++) begin
        sb = d.s >> j;
        if (sb[0]) c.p = lvl(c.p, 1 << j, d.op);
      end
    end

    if (k < P - 1) begin : r
      stage_t q;
      always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in)   q <= '0;
        else if (adv) q <= c;
      end
    end
  end

  assign last = stg[P-1].c;

  logic [N-1:0] y_d;
  logic         zf_d;
  logic         vf_d;
  logic         cf_d;

  always_comb begin
    int           sn;
    int           sm1;
    logic [N-1:0] rt;
    logic [N-1:0] lt;
    logic [N-1:0] mask;
    logic [N-1:0] diff;
    y_d = last.p;
    if (last.op == 3'b101) y_d[N-1] = last.x[N-1];
    sn   = int'(last.s);
    sm1  = (sn == 0) ? 0 : sn - 1;
    rt   = last.x >> sm1;
    lt   = last.x << sm1;
    // Bits x[N-2 : N-1-s] are the ones pushed through the held sign bit.
    mask = ({N{1'b1}} << (N - 1 - sn)) & {1'b0, {(N-1){1'b1}}};
    diff = last.x ^ {N{last.x[N-1]}};
    vf_d = (last.op == 3'b101) && (sn != 0) && |(diff & mask);
    zf_d = ~|y_d;
    cf_d = 1'b0;
    if (sn != 0) begin
      unique case (1'b1)
        (last.op[2] && last.op[1]):   cf_d = y_d[0];
        (!last.op[2] && last.op[1]):  cf_d = y_d[N-1];
        (last.op[2] && !last.op[1]):  cf_d = lt[N-1];
        default:                      cf_d = rt[0];
      endcase
    end
  end

  logic [N-1:0] y_q;
  logic         zf_q;
  logic         vf_q;
  logic         cf_q;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      valid_q <= 1'b0;
      y_q     <= '0;
      zf_q    <= 1'b0;
      vf_q    <= 1'b0;
      cf_q    <= 1'b0;
    end else if (adv) begin
      valid_q <= last.v;
      y_q     <= y_d;
      zf_q    <= zf_d;
      vf_q    <= vf_d;
      cf_q    <= cf_d;
    end
  end

  assign bus.valid_out = valid_q;
  assign bus.y_out     = y_q;
  assign bus.zf_out    = zf_q;
  assign bus.vf_out    = vf_q;
  assign bus.cf_out    = cf_q;
endmodule

// File: tb/tb_pipelined_barrelshifter.sv
// Scoreboard bench for pipelined_barrelshifter at D_SIZE=8, PIPE_STAGES=2.
// Expected {y,zf,vf,cf} come from a bit-level reference model.
module tb_pipelined_barrelshifter;
  localparam int D = 8;
  localparam int P = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipelined_barrelshifter_if #(.D_SIZE(D)) bus ();

  pipelined_barrelshifter #(
    .D_SIZE(D),
    .PIPE_STAGES(P)
  ) dut (
    .clk_in(clk),
    .rst_in(rst),
    .bus(bus.slave)
  );

  int errors = 0;
  int checks = 0;
  logic [10:0] sb[$];

  typedef struct {
    logic [2:0]  op;
    logic [7:0]  x;
    logic [2:0]  s;
    logic [10:0] exp;
  } vec_t;

  vec_t vecs[6] = '{
    '{3'b001, 8'h96, 3'd3, {8'hF2, 3'b001}},
    '{3'b101, 8'h30, 3'd2, {8'h40, 3'b010}},
    '{3'b101, 8'hE0, 3'd2, {8'h80, 3'b001}},
    '{3'b110, 8'h81, 3'd1, {8'h03, 3'b001}},
    '{3'b010, 8'h81, 3'd1, {8'hC0, 3'b001}},
    '{3'b000, 8'h01, 3'd1, {8'h00, 3'b101}}
  };

  function automatic logic [10:0] model(
    input logic [7:0] x,
    input logic [2:0] s,
    input logic [2:0] op
  );
    int n;
    int src;
    logic [7:0] y;
    logic vf;
    logic cf;
    n = int'(s);
    y = '0;
    for (int i = 0; i < 8; i++) begin
      if (!op[2]) begin
        src = i + n;
        if (src < 8)    y[i] = x[src];
        else if (op[1]) y[i] = x[src-8];
        else if (op[0]) y[i] = x[7];
        else            y[i] = 1'b0;
      end else begin
        src = i - n;
        if (src >= 0)   y[i] = x[src];
        else if (op[1]) y[i] = x[src+8];
        else            y[i] = 1'b0;
      end
    end
    if (op == 3'b101) y[7] = x[7];
    vf = 1'b0;
    if (op == 3'b101 && n != 0)
      for (int i = 7 - n; i <= 6; i++)
        if (x[i] != x[7]) vf = 1'b1;
    cf = 1'b0;
    if (n != 0) begin
      if (op[1]) cf = op[2] ? y[0] : y[7];
      else       cf = op[2] ? x[8-n] : x[n-1];
    end
    return {y, (y == 8'h00), vf, cf};
  endfunction

  task automatic drive(
    input logic v, input logic [7:0] x,
    input logic [2:0] s, input logic [2:0] op
  );
    bus.valid_in = v;
    bus.x_in     = x;
    bus.s_in     = s;
    bus.op_in    = op;
  endtask

  task automatic tick(
    output logic fin, output logic fout,
    output logic [10:0] obs
  );
    #1;
    fin  = bus.valid_in && bus.ready_out;
    fout = bus.valid_out && bus.ready_in;
    obs  = {bus.y_out, bus.zf_out, bus.vf_out, bus.cf_out};
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    #1;
    checks++;
    if (bus.valid_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid got=%b exp=0", bus.valid_out);
    end
    checks++;
    if ({bus.y_out, bus.zf_out, bus.vf_out, bus.cf_out} !== 11'h0) begin
      errors++;
      $display("FAIL reset_out got=%h exp=000",
               {bus.y_out, bus.zf_out, bus.vf_out, bus.cf_out});
    end
    checks++;
    if (bus.ready_out !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready got=%b exp=1", bus.ready_out);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_directed();
    logic fin, fout;
    logic [10:0] obs;
    bus.ready_in = 1'b1;
    foreach (vecs[i]) begin
      drive(1'b1, vecs[i].x, vecs[i].s, vecs[i].op);
      tick(fin, fout, obs);
      checks++;
      if (fin !== 1'b1) begin
        errors++;
        $display("FAIL dir%0d_accept got=%b exp=1", i, fin);
      end
      drive(1'b0, 8'h00, 3'd0, 3'd0);
      tick(fin, fout, obs);
      checks++;
      if (fout !== 1'b0) begin
        errors++;
        $display("FAIL dir%0d_early got=%b exp=0", i, fout);
      end
      tick(fin, fout, obs);
      checks++;
      if (fout !== 1'b1 || obs !== vecs[i].exp) begin
        errors++;
        $display("FAIL dir%0d_result valid=%b got=%h exp=%h",
                 i, fout, obs, vecs[i].exp);
      end
    end
    tick(fin, fout, obs);
  endtask

  task automatic test_back_to_back();
    logic fin, fout;
    logic [10:0] obs;
    logic [10:0] e;
    logic [7:0] x;
    logic [2:0] s, op;
    int outs, first, lastt, t;
    outs = 0; first = -1; lastt = -1; t = 0;
    bus.ready_in = 1'b1;
    for (int i = 0; i < 16 + 6; i++) begin
      x  = 8'($urandom);
      s  = 3'($urandom_range(0, 7));
      op = 3'($urandom_range(0, 7));
      drive(i < 16, x, s, op);
      tick(fin, fout, obs);
      if (fin) sb.push_back(model(x, s, op));
      if (fout) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL b2b_extra got=%h", obs);
        end else begin
          e = sb.pop_front();
          if (obs !== e) begin
            errors++;
            $display("FAIL b2b_data got=%h exp=%h", obs, e);
          end
        end
        if (first < 0) first = t;
        lastt = t;
        outs++;
      end
      t++;
    end
    checks++;
    if (outs != 16 || lastt - first != 15) begin
      errors++;
      $display("FAIL b2b_rate got=%0d outs over %0d cycles exp=16 over 16",
               outs, lastt - first + 1);
    end
  endtask

  task automatic test_backpressure();
    logic fin, fout;
    logic [10:0] obs;
    logic [10:0] e;
    logic [10:0] held;
    logic [7:0] px[3];
    logic [2:0] ps[3], pop[3];
    int issued, outs;
    logic have_held;
    issued = 0; outs = 0; have_held = 1'b0; held = '0;
    for (int i = 0; i < 3; i++) begin
      px[i] = 8'($urandom); ps[i] = 3'($urandom_range(1, 7));
      pop[i] = 3'($urandom_range(0, 7));
    end
    bus.ready_in = 1'b0;
    for (int t = 0; t < 6; t++) begin
      drive(1'b1, px[issued], ps[issued], pop[issued]);
      #1;
      if (!bus.ready_out)
        drive(1'b1, 8'($urandom), 3'($urandom), 3'($urandom));
      if (bus.valid_out) begin
        if (have_held) begin
          checks++;
          if (obs !== held) begin
            errors++;
            $display("FAIL bp_hold got=%h exp=%h", obs, held);
          end
        end
        have_held = 1'b1;
      end
      tick(fin, fout, obs);
      if (have_held && held === '0) held = obs;
      if (fin) begin
        sb.push_back(model(px[issued], ps[issued], pop[issued]));
        issued++;
      end
    end
    checks++;
    if (issued != 2 || bus.ready_out !== 1'b0) begin
      errors++;
      $display("FAIL bp_stall got=%0d accepted ready=%b exp=2 ready=0",
               issued, bus.ready_out);
    end
    bus.ready_in = 1'b1;
    for (int t = 0; t < 15; t++) begin
      if (issued < 3) drive(1'b1, px[issued], ps[issued], pop[issued]);
      else            drive(1'b0, 8'h00, 3'd0, 3'd0);
      tick(fin, fout, obs);
      if (fin) begin
        sb.push_back(model(px[issued], ps[issued], pop[issued]));
        issued++;
      end
      if (fout) begin
        outs++;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL bp_extra got=%h", obs);
        end else begin
          e = sb.pop_front();
          if (obs !== e) begin
            errors++;
            $display("FAIL bp_data got=%h exp=%h", obs, e);
          end
        end
      end
    end
    checks++;
    if (outs != 3 || sb.size() != 0) begin
      errors++;
      $display("FAIL bp_drain got=%0d outs left=%0d exp=3 left=0",
               outs, sb.size());
    end
  endtask

  task automatic test_random_flow();
    logic fin, fout;
    logic [10:0] obs;
    logic [10:0] e;
    logic [7:0] x;
    logic [2:0] s, op;
    for (int t = 0; t < 100; t++) begin
      x  = 8'($urandom);
      s  = 3'($urandom);
      op = 3'($urandom);
      drive((t < 80) && ($urandom_range(0, 3) != 0), x, s, op);
      bus.ready_in = (t >= 80) || ($urandom_range(0, 9) < 7);
      tick(fin, fout, obs);
      if (fin) sb.push_back(model(x, s, op));
      if (fout) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL rand_extra got=%h", obs);
        end else begin
          e = sb.pop_front();
          if (obs !== e) begin
            errors++;
            $display("FAIL rand_data got=%h exp=%h", obs, e);
          end
        end
      end
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL rand_lost got=%0d pending exp=0", sb.size());
    end
    sb.delete();
  endtask

  task automatic test_reset_midflight();
    logic fin, fout;
    logic [10:0] obs;
    int stale;
    stale = 0;
    bus.ready_in = 1'b1;
    drive(1'b1, 8'hFF, 3'd1, 3'b100);
    tick(fin, fout, obs);
    drive(1'b1, 8'h7F, 3'd2, 3'b101);
    tick(fin, fout, obs);
    drive(1'b0, 8'h00, 3'd0, 3'd0);
    rst = 1'b1;
    #1;
    checks++;
    if (bus.valid_out !== 1'b0 ||
        {bus.y_out, bus.zf_out, bus.vf_out, bus.cf_out} !== 11'h0) begin
      errors++;
      $display("FAIL rst_mid got=%b/%h exp=0/000", bus.valid_out,
               {bus.y_out, bus.zf_out, bus.vf_out, bus.cf_out});
    end
    @(negedge clk);
    rst = 1'b0;
    for (int t = 0; t < 4; t++) begin
      tick(fin, fout, obs);
      if (fout) stale++;
    end
    checks++;
    if (stale != 0) begin
      errors++;
      $display("FAIL rst_stale got=%0d exp=0", stale);
    end
    drive(1'b1, 8'h96, 3'd3, 3'b001);
    tick(fin, fout, obs);
    drive(1'b0, 8'h00, 3'd0, 3'd0);
    tick(fin, fout, obs);
    checks++;
    if (fout !== 1'b0) begin
      errors++;
      $display("FAIL rst_new_early got=%b exp=0", fout);
    end
    tick(fin, fout, obs);
    checks++;
    if (fout !== 1'b1 || obs !== {8'hF2, 3'b001}) begin
      errors++;
      $display("FAIL rst_new_result valid=%b got=%h exp=%h",
               fout, obs, {8'hF2, 3'b001});
    end
  endtask

  initial begin
    bus.ready_in = 1'b0;
    drive(1'b0, 8'h00, 3'd0, 3'd0);
    test_reset();
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_random_flow();
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
